// File: rtl/uart_boot_loader_pkg.sv
// Shared constants for the UART boot loader: sync byte, one-hot FSM encoding,
// UART framing and a helper that turns a word index into a byte address.
package uart_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef logic [6:0] state_t;

  localparam state_t ST_IDLE = 7'b0000001;
  localparam state_t ST_LEN0 = 7'b0000010;
  localparam state_t ST_LEN1 = 7'b0000100;
  localparam state_t ST_DATA = 7'b0001000;
  localparam state_t ST_CSUM = 7'b0010000;
  localparam state_t ST_DONE = 7'b0100000;
  localparam state_t ST_ERR  = 7'b1000000;

  // States in which a transfer is in flight (timeout and framing errors apply).
  localparam state_t ST_ACTIVE_MASK = ST_LEN0 | ST_LEN1 | ST_DATA | ST_CSUM;

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, glitch-filtered start detection,
// mid-bit sampling and stop-bit framing check.
module uart_rx_byte
  import uart_boot_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             meta_reg;
  logic             sync_reg;
  logic             prev_reg;
  logic [1:0]       rx_state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic             valid_reg;
  logic             ferr_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_reg     <= 1'b1;
      sync_reg     <= 1'b1;
      prev_reg     <= 1'b1;
      rx_state_reg <= RX_IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      valid_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      meta_reg  <= rx;
      sync_reg  <= meta_reg;
      prev_reg  <= sync_reg;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (prev_reg && !sync_reg) begin
            rx_state_reg <= RX_START;
            cnt_reg      <= '0;
          end
        end
        RX_START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (sync_reg) begin
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_state_reg <= RX_DATA;
              bit_reg      <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {sync_reg, shift_reg[7:1]};
            if (bit_reg == BIT_LAST) begin
              rx_state_reg <= RX_STOP;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg      <= '0;
            rx_state_reg <= RX_IDLE;
            if (sync_reg) begin
              valid_reg <= 1'b1;
            end else begin
              ferr_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = valid_reg;
  assign frame_err  = ferr_reg;
  assign rx_byte    = shift_reg;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a framed firmware image over UART, writes it into
// instruction memory, verifies the checksum and then releases the core.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 115200,
  parameter int IMEM_WORDS     = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [3:0]  imem_mask,
  output logic        core_rst_n,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(IMEM_WORDS);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  state_t           state_reg, state_next;
  logic [15:0]      len_reg, len_next;
  logic [15:0]      idx_reg, idx_next;
  logic [7:0]       sum_reg, sum_next;
  logic [31:0]      word_reg, word_next;
  logic [1:0]       lane_reg, lane_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             we_reg, we_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [3:0]       mask_reg, mask_next;

  logic        active;
  logic        timeout;
  logic [15:0] len_rx;

  // Each incoming data byte lands in the lane selected by lane_reg (LSB first).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_next[8*gi +: 8] =
      (state_reg == ST_DATA && byte_valid && lane_reg == 2'(gi)) ? rx_byte
                                                                 : word_reg[8*gi +: 8];
  end

  assign active  = |(state_reg & ST_ACTIVE_MASK);
  assign timeout = active && !byte_valid && (gap_reg == GAP_LAST);
  assign len_rx  = {rx_byte, len_reg[7:0]};

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    sum_next   = sum_reg;
    lane_next  = lane_reg;
    gap_next   = '0;
    we_next    = 1'b0;
    mask_next  = 4'h0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;

    if (active && !byte_valid) begin
      gap_next = gap_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE, ST_ERR: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          state_next = ST_LEN0;
          sum_next   = '0;
          idx_next   = '0;
          lane_next  = '0;
        end
      end
      ST_LEN0: begin
        if (byte_valid) begin
          len_next[7:0] = rx_byte;
          state_next    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_valid) begin
          len_next = len_rx;
          if ({1'b0, len_rx} > MAX_WORDS) begin
            state_next = ST_ERR;
          end else if (len_rx == 16'd0) begin
            state_next = ST_CSUM;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          sum_next  = sum_reg + rx_byte;
          lane_next = lane_reg + 1'b1;
          if (lane_reg == 2'd3) begin
            we_next    = 1'b1;
            mask_next  = 4'hF;
            addr_next  = word_addr(idx_reg);
            wdata_next = word_next;
            idx_next   = idx_reg + 16'd1;
            if (idx_reg + 16'd1 == len_reg) begin
              state_next = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (byte_valid) begin
          state_next = (rx_byte == sum_reg) ? ST_DONE : ST_ERR;
        end
      end
      default: ;
    endcase

    // A received byte always wins over a coincident timeout.
    if (active && !byte_valid && (frame_err || timeout)) begin
      state_next = ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      word_reg  <= '0;
      lane_reg  <= '0;
      gap_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      mask_reg  <= 4'h0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      sum_reg   <= sum_next;
      word_reg  <= word_next;
      lane_reg  <= lane_next;
      gap_reg   <= gap_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      mask_reg  <= mask_next;
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign imem_mask  = mask_reg;
  assign boot_done  = (state_reg == ST_DONE);
  assign core_rst_n = (state_reg == ST_DONE);
  assign boot_err   = (state_reg == ST_ERR);

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream boot stage for the RV32I core.
- After reset it holds the core in reset and receives a firmware image over the UART rx line. It writes the image word-by-word into instruction memory through that memory's write port, checks a checksum, then releases the core to fetch from address 0.
- This replaces the fixed hex-file preload, so firmware can change without resynthesis.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. Bit period DIV = CLK_FREQ/BAUD, integer division, must be >= 4.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words. It is the maximum accepted image length.
- TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes once a transfer has started.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- uart_rx  input  1  asynchronous serial input, idle high.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  32  byte address of the write, always word aligned.
- imem_wdata  output  32  word to write.
- imem_mask  output  4  byte enables. Always 4'hF when imem_we=1, otherwise 4'h0.
- core_rst_n  output  1  active-low reset to the core. 0 holds the core.
- boot_done  output  1  image loaded and verified. Level signal.
- boot_err  output  1  last transfer failed. Level signal.

Behaviour:
- Reset (rst=0 at posedge) sets: imem_we=0, imem_addr=0, imem_wdata=0, imem_mask=0, core_rst_n=0, boot_done=0, boot_err=0, FSM=IDLE, receiver idle. Reset mid-transfer abandons the transfer; words already written are not erased.
- Frame format, all bytes 8N1, LSB first:
  - SYNC byte 0xA5.
  - LEN_L, LEN_H: word count N, 16-bit little endian.
  - N words, each 4 bytes little endian.
  - CSUM: sum of all data bytes mod 256. Length bytes are excluded.
- Receiver:
  - uart_rx passes through a 2-FF synchronizer.
  - A start condition is a falling edge while idle. The line is resampled at DIV/2; if it is high, the start is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every DIV cycles. The stop bit is sampled at the middle of bit 9.
  - Stop bit = 1 gives a byte_valid pulse (1 cycle) with byte[7:0].
  - Stop bit = 0 gives a frame_err pulse and no byte_valid.
  - The receiver is ready for a new start edge immediately after the stop-bit sample.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: bytes other than 0xA5 are ignored, as is frame_err. 0xA5 goes to LEN0, clears boot_err, clears the running sum and word index.
  - LEN0: latch the low byte, go to LEN1.
  - LEN1: latch the high byte.
    - N > IMEM_WORDS goes to ERR.
    - N = 0 goes to CSUM.
    - Otherwise go to DATA.
  - DATA: shift each byte into bits [8k+7:8k] for k = 0..3 and add it to the sum.
    - The cycle after the 4th byte: imem_we=1, imem_addr=index*4, imem_wdata=word, imem_mask=4'hF.
    - Then index increments. When index reaches N, go to CSUM.
  - CSUM: a byte equal to sum[7:0] goes to DONE; any other value goes to ERR.
  - DONE: core_rst_n=1 and boot_done=1 from the cycle after the CSUM byte's byte_valid. All further rx traffic is ignored until rst.
  - ERR: boot_err=1, core_rst_n=0. A 0xA5 byte restarts the sequence exactly as in IDLE.
- Timeout: in LEN0, LEN1, DATA and CSUM a gap counter resets on every byte_valid. If it reaches TIMEOUT_CYCLES, go to ERR.
- frame_err in LEN0, LEN1, DATA or CSUM goes to ERR.
- Simultaneous events: timeout and byte_valid in the same cycle resolve in favour of byte_valid.
- Sum is 8-bit and wraps modulo 256. Word index is 16 bits.

Decomposition:
- Shared package holds:
  - SYNC_BYTE = 8'hA5.
  - FSM state encoding as a one-hot localparam set (IDLE..ERR).
  - UART framing constants: 8 data bits, 1 stop bit.
- Sub-module uart_rx_byte holds the synchronizer, start detection, bit sampling and framing check. Its outputs are byte_valid, byte[7:0] and frame_err.
- The top-level module contains the FSM, word assembly, checksum, timeout and memory write.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so DIV=10; TIMEOUT_CYCLES=500):
1. Send A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 82. Required:
   - imem_we pulses twice: addr 0 with data 0x00000013, then addr 4 with data 0x0000006F.
   - boot_done=1 and core_rst_n=1 the cycle after the CSUM byte.
2. Send the same frame with CSUM=0x83. Required: boot_err=1, core_rst_n=0. Then resend the correct frame: boot_err=0, boot_done=1.
3. Send 00 FF A5 00 00 00. Required: leading bytes ignored, no imem_we, boot_done=1.
4. Send A5 01 04 (N=1025 > 1024). Required: ERR immediately after LEN_H, no write.
5. Send A5 01 00 13, then idle 600 cycles. Required: boot_err=1 after 500 idle cycles, no imem_we.
6. Assert rst mid-DATA, then send a byte with stop bit 0 in DATA. Required:
   - rst returns all outputs to their reset values.
   - A subsequent valid transfer loads correctly.
   - A stop-bit-0 byte in DATA gives boot_err=1.
